// File: rtl/alu_divider_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per clock; sign and divide-by-zero/overflow fix-up in a final cycle.
module alu_divider_seq #(
   parameter int unsigned N     = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         sel_signed_i,
   input  logic [N-1:0] dividend_i,
   input  logic [N-1:0] divisor_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] quotient_o,
   output logic [N-1:0] remainder_o,
   output logic         div_zero_o
);

   typedef enum logic [1:0] {StIdle, StDiv, StFix, StDone} state_e;

   localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     rem_q, rem_d;
   logic [N-1:0]     quo_q, quo_d;
   logic [N-1:0]     dsr_q, dsr_d;
   logic [N-1:0]     dvd_q, dvd_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;
   logic [N-1:0]     quotient_q, quotient_d;
   logic [N-1:0]     remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;

   logic             a_neg, b_neg;
   logic [N:0]       rem_shift;
   logic [N+1:0]     trial;

   // sel_signed_i = 0 selects signed operation
   assign a_neg     = ~sel_signed_i & dividend_i[N-1];
   assign b_neg     = ~sel_signed_i & divisor_i[N-1];
   assign rem_shift = {rem_q, quo_q[N-1]};
   assign trial     = {1'b0, rem_shift} - {2'b00, dsr_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start_i) state_d = StDiv;
         StDiv:   if (cnt_q == CNT_W'(1)) state_d = StFix;
         StFix:   state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dsr_d       = dsr_q;
      dvd_d       = dvd_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      dz_d        = dz_q;
      ovf_d       = ovf_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               dvd_d   = dividend_i;
               quo_d   = a_neg ? -dividend_i : dividend_i;
               dsr_d   = b_neg ? -divisor_i : divisor_i;
               rem_d   = '0;
               cnt_d   = CNT_W'(N);
               q_neg_d = a_neg ^ b_neg;
               r_neg_d = a_neg;
               dz_d    = (divisor_i == '0);
               ovf_d   = ~sel_signed_i && (dividend_i == MinVal) && (&divisor_i);
            end
         end
         StDiv: begin
            // trial[N+1] is the borrow: set means the shifted remainder is below the divisor
            quo_d = {quo_q[N-2:0], ~trial[N+1]};
            rem_d = trial[N+1] ? rem_shift[N-1:0] : trial[N-1:0];
            cnt_d = cnt_q - CNT_W'(1);
         end
         StFix: begin
            div_zero_d = dz_q;
            if (dz_q) begin
               quotient_d  = '1;
               remainder_d = dvd_q;
            end else if (ovf_q) begin
               quotient_d  = dvd_q;
               remainder_d = '0;
            end else begin
               quotient_d  = q_neg_q ? -quo_q : quo_q;
               remainder_d = r_neg_q ? -rem_q : rem_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dsr_q       <= '0;
         dvd_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dsr_q       <= dsr_d;
         dvd_q       <= dvd_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         dz_q        <= dz_d;
         ovf_q       <= ovf_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign busy_o      = (state_q == StDiv) || (state_q == StFix);
   assign done_o      = (state_q == StDone);
   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;
   assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_alu_divider_seq.sv
// Randomised scoreboard bench for alu_divider_seq: arithmetic reference model,
// per-cycle checks of busy/done timing and held result outputs.
module tb_alu_divider_seq;

   localparam int unsigned N     = 32;
   localparam int unsigned CNT_W = 6;
   localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};

   logic         clk = 1'b0;
   logic         rst_i, start_i, sel_signed_i;
   logic [N-1:0] dividend_i, divisor_i;
   logic         busy_o, done_o, div_zero_o;
   logic [N-1:0] quotient_o, remainder_o;

   always #5 clk = ~clk;

   alu_divider_seq #(.N(N), .CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .sel_signed_i (sel_signed_i),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .quotient_o   (quotient_o),
      .remainder_o  (remainder_o),
      .div_zero_o   (div_zero_o)
   );

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      int           e0;
   } exp_t;

   exp_t         scb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           free_edge = 0;
   int           ci;
   bit           mon_en = 0;
   logic         exp_busy, exp_done;
   logic [N-1:0] last_q = '0, last_r = '0;
   logic         last_dz = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic uns);
      exp_t e;
      logic signed [N-1:0] sa, sd;
      e.dz = (b == '0);
      e.e0 = 0;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else if (uns) begin
         e.q = a / b;
         e.r = a % b;
      end else if (a == MinVal && b == '1) begin
         e.q = a;
         e.r = '0;
      end else begin
         sa  = a;
         sd  = b;
         e.q = sa / sd;
         e.r = sa % sd;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   // Monitor: expected control timing derives from the start edge of the pending op
   always @(negedge clk) begin
      if (mon_en) begin
         ci       = cyc + 1;
         exp_busy = 1'b0;
         exp_done = 1'b0;
         if (scb.size() > 0) begin
            exp_busy = (ci > scb[0].e0) && (ci <= scb[0].e0 + int'(N) + 1);
            exp_done = (ci == scb[0].e0 + int'(N) + 2);
         end
         chk("busy", N'(busy_o), N'(exp_busy));
         chk("done", N'(done_o), N'(exp_done));
         if (exp_done) begin
            last_q  = scb[0].q;
            last_r  = scb[0].r;
            last_dz = scb[0].dz;
            void'(scb.pop_front());
         end
         chk("quotient", quotient_o, last_q);
         chk("remainder", remainder_o, last_r);
         chk("div_zero", N'(div_zero_o), N'(last_dz));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic uns);
      exp_t e;
      while (cyc + 1 < free_edge) tick();
      dividend_i   = a;
      divisor_i    = b;
      sel_signed_i = uns;
      start_i      = 1'b1;
      e            = model(a, b, uns);
      e.e0         = cyc + 1;
      scb.push_back(e);
      free_edge    = e.e0 + int'(N) + 3;
      tick();
      start_i      = 1'b0;
      dividend_i   = $urandom;
      divisor_i    = $urandom;
      sel_signed_i = 1'($urandom);
   endtask

   // Pulse start at a cycle where the divider must ignore it
   task automatic stray_pulse(input int edge_no);
      while (cyc + 1 < edge_no) tick();
      dividend_i   = $urandom;
      divisor_i    = $urandom_range(1, 9);
      sel_signed_i = 1'($urandom);
      start_i      = 1'b1;
      tick();
      start_i      = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      exp_t         e;
      logic [N-1:0] ra, rb;
      int           e0;
      rst_i        = 1'b1;
      start_i      = 1'b0;
      sel_signed_i = 1'b0;
      dividend_i   = '0;
      divisor_i    = '0;
      repeat (2) tick();
      mon_en = 1;
      tick();
      rst_i     = 1'b0;
      free_edge = cyc + 1;

      issue(32'd100, 32'd7, 1'b1);
      issue(32'hFFFF_FFF9, 32'd2, 1'b0);
      issue(32'd7, 32'hFFFF_FFFE, 1'b0);
      issue(32'h1234_5678, 32'd0, 1'b0);
      issue(32'h1234_5678, 32'd0, 1'b1);
      issue(MinVal, 32'hFFFF_FFFF, 1'b0);
      issue(MinVal, 32'hFFFF_FFFF, 1'b1);

      // start held high: accepted again only in the first idle cycle after done
      while (cyc + 1 < free_edge) tick();
      start_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         while (cyc + 1 < free_edge) tick();
         ra           = $urandom;
         rb           = $urandom_range(1, 1000);
         dividend_i   = ra;
         divisor_i    = rb;
         sel_signed_i = 1'(k);
         e            = model(ra, rb, 1'(k));
         e.e0         = cyc + 1;
         scb.push_back(e);
         free_edge    = e.e0 + int'(N) + 3;
         tick();
         dividend_i   = $urandom;
         divisor_i    = $urandom;
         sel_signed_i = 1'($urandom);
      end
      while (cyc + 1 < free_edge - 1) tick();
      start_i = 1'b0;

      // stray starts mid-operation and in the done cycle
      issue(32'd1000, 32'd3, 1'b1);
      e0 = free_edge - int'(N) - 3;
      stray_pulse(e0 + 5);
      stray_pulse(e0 + int'(N) + 2);

      // reset in the middle of an operation
      issue(32'hDEAD_BEEF, 32'd13, 1'b1);
      repeat (10) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      scb.delete();
      last_q    = '0;
      last_r    = '0;
      last_dz   = 1'b0;
      free_edge = cyc + 1;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

      // reset and start together: reset wins, nothing starts
      while (cyc + 1 < free_edge) tick();
      rst_i   = 1'b1;
      start_i = 1'b1;
      tick();
      rst_i   = 1'b0;
      start_i = 1'b0;
      last_q    = '0;
      last_r    = '0;
      last_dz   = 1'b0;
      free_edge = cyc + 1;

      for (int i = 0; i < 40; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? MinVal : 32'($urandom);
         case ($urandom_range(0, 4))
            0:       rb = '0;
            1:       rb = '1;
            2:       rb = 32'($urandom_range(1, 15));
            3:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         issue(ra, rb, 1'($urandom));
      end

      while (cyc + 1 < free_edge + 2) tick();
      chk("scoreboard_empty", N'(scb.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
